// File: rtl/h2c_pack_pkg.sv
// rtl/h2c_pack_pkg.sv - shared types and derived sizes for the H2C packing controller
package h2c_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DISCARD
    } state_t;

    localparam int DEF_AXIS_W    = 64;
    localparam int DEF_RAM_W     = 128;
    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_SLOT_AW   = 9;

    function automatic int calc_aw(input int num_slots, input int slot_aw);
        return $clog2(num_slots) + slot_aw;
    endfunction

    function automatic int calc_r(input int ram_w, input int axis_w);
        return ram_w / axis_w;
    endfunction

endpackage

// File: rtl/h2c_pack_ctlr_slot_alloc.sv
// rtl/h2c_pack_ctlr_slot_alloc.sv - lowest-index free slot priority encoder
module slot_alloc #(
    parameter int NUM_SLOTS = 8
) (
    input  logic [NUM_SLOTS-1:0]         free,
    output logic [$clog2(NUM_SLOTS)-1:0] idx,
    output logic                         any_free
);

    always_comb begin
        idx      = '0;
        any_free = |free;
        // Scan downward so the lowest free index is the last assignment.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free[i]) begin
                idx = ($clog2(NUM_SLOTS))'(i);
            end
        end
    end

endmodule

// File: rtl/h2c_pack_ctlr.sv
// rtl/h2c_pack_ctlr.sv - packs H2C stream beats into RAM words across a ring of packet slots
module h2c_pack_ctlr
    import h2c_pack_pkg::*;
#(
    parameter int AXIS_W    = DEF_AXIS_W,
    parameter int RAM_W     = DEF_RAM_W,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int SLOT_AW   = DEF_SLOT_AW
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [AXIS_W-1:0]                     s_axis_tdata,
    input  logic [AXIS_W/8-1:0]                   s_axis_tkeep,
    input  logic                                  s_axis_tlast,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic [RAM_W-1:0]                      WrData,
    output logic                                  WrEn,
    output logic [calc_aw(NUM_SLOTS,SLOT_AW)-1:0] WrAddr,
    output logic [NUM_SLOTS-1:0]                  DataValid,
    input  logic [NUM_SLOTS-1:0]                  RamValid,
    output logic [NUM_SLOTS-1:0]                  SlotErr,
    input  logic [$clog2(NUM_SLOTS)-1:0]          RdSlot,
    output logic [SLOT_AW:0]                      RdLen,
    output logic [15:0]                           OvfCnt
);

    localparam int R  = calc_r(RAM_W, AXIS_W);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int KW = (R > 1) ? $clog2(R) : 1;
    localparam int LW = SLOT_AW + 1;
    localparam int NB = AXIS_W / 8;

    state_t               state;
    logic                 tready_q;
    logic [SW-1:0]        slot_q;
    logic [SW-1:0]        alloc_idx_q;
    logic [KW-1:0]        lane_q;
    logic [LW-1:0]        widx_q;
    logic [RAM_W-1:0]     acc_q;
    logic [NUM_SLOTS-1:0] dv_q;
    logic [NUM_SLOTS-1:0] err_q;
    logic [LW-1:0]        len_q [NUM_SLOTS];
    logic                 commit_q;
    logic                 commit_err_q;
    logic [SW-1:0]        commit_slot_q;
    logic [LW-1:0]        commit_len_q;
    logic [15:0]          ovf_q;

    logic                 accept;
    logic                 finishing;
    logic                 word_done;
    logic                 drop;
    logic [SW-1:0]        in_slot;
    logic [LW-1:0]        cur_widx;
    logic [AXIS_W-1:0]    beat_masked;
    logic [RAM_W-1:0]     merged;
    logic [NUM_SLOTS-1:0] rel;
    logic [NUM_SLOTS-1:0] commit_oh;
    logic [NUM_SLOTS-1:0] dv_n;
    logic [NUM_SLOTS-1:0] pend_n;
    logic [NUM_SLOTS-1:0] free_n;
    logic [SW-1:0]        alloc_idx_n;
    logic                 any_free_n;
    state_t               state_n;

    assign accept    = s_axis_tvalid & tready_q;
    assign finishing = accept & s_axis_tlast;
    assign in_slot   = (state == ST_IDLE) ? alloc_idx_q : slot_q;
    assign cur_widx  = (state == ST_IDLE) ? '0 : widx_q;
    assign drop      = (state == ST_DISCARD) | cur_widx[SLOT_AW];
    assign word_done = (lane_q == KW'(R - 1)) | s_axis_tlast;
    assign rel       = RamValid & dv_q;
    assign commit_oh = commit_q ? (NUM_SLOTS'(1) << commit_slot_q) : '0;

    always_comb begin
        beat_masked = '0;
        for (int b = 0; b < NB; b++) begin
            beat_masked[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
        end
    end

    always_comb begin
        merged = acc_q;
        for (int k = 0; k < R; k++) begin
            if (lane_q == KW'(k)) begin
                merged[k*AXIS_W +: AXIS_W] = beat_masked;
            end
        end
    end

    always_comb begin
        state_n = state;
        if (accept) begin
            case (state)
                ST_IDLE:    state_n = s_axis_tlast ? ST_IDLE : ST_FILL;
                ST_FILL:    state_n = s_axis_tlast ? ST_IDLE :
                                      (cur_widx[SLOT_AW] ? ST_DISCARD : ST_FILL);
                ST_DISCARD: state_n = s_axis_tlast ? ST_IDLE : ST_DISCARD;
                default:    state_n = ST_IDLE;
            endcase
        end
    end

    // A slot whose tlast was just taken is still pending commit; keep it out of allocation.
    assign dv_n   = (dv_q & ~rel) | commit_oh;
    assign pend_n = finishing ? (NUM_SLOTS'(1) << in_slot) : '0;
    assign free_n = ~(dv_n | pend_n);

    slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_slot_alloc (
        .free     (free_n),
        .idx      (alloc_idx_n),
        .any_free (any_free_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tready_q      <= 1'b0;
            slot_q        <= '0;
            alloc_idx_q   <= '0;
            lane_q        <= '0;
            widx_q        <= '0;
            acc_q         <= '0;
            dv_q          <= '0;
            err_q         <= '0;
            commit_q      <= 1'b0;
            commit_err_q  <= 1'b0;
            commit_slot_q <= '0;
            commit_len_q  <= '0;
            ovf_q         <= '0;
            WrEn          <= 1'b0;
            WrData        <= '0;
            WrAddr        <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                len_q[s] <= '0;
            end
        end else begin
            state       <= state_n;
            tready_q    <= (state_n != ST_IDLE) | any_free_n;
            alloc_idx_q <= alloc_idx_n;
            WrEn        <= 1'b0;
            commit_q    <= finishing;

            if (finishing) begin
                commit_slot_q <= in_slot;
                commit_err_q  <= drop;
                commit_len_q  <= drop ? cur_widx : cur_widx + LW'(1);
            end

            if (accept) begin
                if (state == ST_IDLE) begin
                    slot_q <= alloc_idx_q;
                end
                if (!drop) begin
                    if (word_done) begin
                        WrEn   <= 1'b1;
                        WrData <= merged;
                        WrAddr <= {in_slot, cur_widx[SLOT_AW-1:0]};
                        widx_q <= cur_widx + LW'(1);
                        lane_q <= '0;
                        acc_q  <= '0;
                    end else begin
                        acc_q  <= merged;
                        lane_q <= lane_q + KW'(1);
                        widx_q <= cur_widx;
                    end
                end
            end

            dv_q  <= dv_n;
            err_q <= (err_q & ~rel) | (commit_err_q ? commit_oh : '0);
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (commit_q && commit_slot_q == SW'(s)) begin
                    len_q[s] <= commit_len_q;
                end else if (rel[s]) begin
                    len_q[s] <= '0;
                end
            end
            if (commit_q && commit_err_q && ovf_q != 16'hFFFF) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    assign s_axis_tready = tready_q;
    assign DataValid     = dv_q;
    assign SlotErr       = err_q;
    assign RdLen         = len_q[RdSlot];
    assign OvfCnt        = ovf_q;

endmodule

// File: tb/tb_h2c_pack_ctlr.sv
// tb/tb_h2c_pack_ctlr.sv - directed self-checking bench for h2c_pack_ctlr
module tb_h2c_pack_ctlr;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  tdata;
    logic [7:0]   tkeep;
    logic         tlast;
    logic         tvalid;
    logic         sel;
    logic         tvalid_a, tvalid_b;

    logic         rdy_a, we_a;
    logic [127:0] wd_a;
    logic [11:0]  wa_a;
    logic [7:0]   dv_a, rv_a, err_a;
    logic [2:0]   rdslot_a;
    logic [9:0]   rdlen_a;
    logic [15:0]  ovf_a;

    logic         rdy_b, we_b;
    logic [127:0] wd_b;
    logic [4:0]   wa_b;
    logic [7:0]   dv_b, rv_b, err_b;
    logic [2:0]   rdslot_b;
    logic [2:0]   rdlen_b;
    logic [15:0]  ovf_b;

    int checks = 0;
    int errors = 0;

    logic [11:0]  qa_addr [$];
    logic [127:0] qa_data [$];
    logic [4:0]   qb_addr [$];
    logic [127:0] qb_data [$];

    always #5 clk = ~clk;

    assign tvalid_a = tvalid & ~sel;
    assign tvalid_b = tvalid & sel;
    assign rv_b     = '0;
    assign rdslot_b = '0;

    h2c_pack_ctlr u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid_a), .s_axis_tready(rdy_a),
        .WrData(wd_a), .WrEn(we_a), .WrAddr(wa_a),
        .DataValid(dv_a), .RamValid(rv_a), .SlotErr(err_a),
        .RdSlot(rdslot_a), .RdLen(rdlen_a), .OvfCnt(ovf_a)
    );

    h2c_pack_ctlr #(.SLOT_AW(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid_b), .s_axis_tready(rdy_b),
        .WrData(wd_b), .WrEn(we_b), .WrAddr(wa_b),
        .DataValid(dv_b), .RamValid(rv_b), .SlotErr(err_b),
        .RdSlot(rdslot_b), .RdLen(rdlen_b), .OvfCnt(ovf_b)
    );

    always @(posedge clk) begin
        #1;
        if (we_a) begin
            qa_addr.push_back(wa_a);
            qa_data.push_back(wd_a);
        end
        if (we_b) begin
            qb_addr.push_back(wa_b);
            qb_data.push_back(wd_b);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        while (!(sel ? rdy_b : rdy_a) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            errors++;
            $display("FAIL send_timeout observed tready=0 expected tready=1 data=%0h", d);
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic clear_q();
        qa_addr.delete();
        qa_data.delete();
        qb_addr.delete();
        qb_data.delete();
    endtask

    initial begin
        rst_n = 1'b0; tvalid = 1'b0; sel = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
        rv_a = '0; rdslot_a = '0;
        repeat (3) @(negedge clk);
        chk("rst_tready", rdy_a, 0);
        chk("rst_wren", we_a, 0);
        chk("rst_wrdata", wd_a, 0);
        chk("rst_wraddr", wa_a, 0);
        chk("rst_dv", dv_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_rdlen", rdlen_a, 0);
        chk("rst_ovf", ovf_a, 0);
        rst_n = 1'b1;

        send(64'h1111111111111111, 8'hFF, 1'b0);
        send(64'h2222222222222222, 8'hFF, 1'b0);
        send(64'h3333333333333333, 8'hFF, 1'b0);
        send(64'h4444444444444444, 8'hFF, 1'b1);
        chk("p1_wren_n1", we_a, 1);
        chk("p1_dv_n1", dv_a, 8'h00);
        @(posedge clk); #1;
        chk("p1_dv_n2", dv_a, 8'h01);
        @(negedge clk);
        chk("p1_nwr", qa_addr.size(), 2);
        chk("p1_addr0", qa_addr[0], 12'h000);
        chk("p1_data0", qa_data[0], {64'h2222222222222222, 64'h1111111111111111});
        chk("p1_addr1", qa_addr[1], 12'h001);
        chk("p1_data1", qa_data[1], {64'h4444444444444444, 64'h3333333333333333});
        chk("p1_rdlen", rdlen_a, 2);
        clear_q();

        send(64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b0);
        send(64'hBBBBBBBBBBBBBBBB, 8'hFF, 1'b0);
        send(64'hCCCCCCCCCCCCCCCC, 8'h0F, 1'b1);
        repeat (3) @(negedge clk);
        rdslot_a = 3'd1;
        #1;
        chk("p2_nwr", qa_addr.size(), 2);
        chk("p2_addr0", qa_addr[0], 12'h200);
        chk("p2_data0", qa_data[0], {64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA});
        chk("p2_addr1", qa_addr[1], 12'h201);
        chk("p2_data1", qa_data[1], {64'h0, 64'h00000000CCCCCCCC});
        chk("p2_rdlen", rdlen_a, 2);
        chk("p2_dv", dv_a, 8'h03);
        clear_q();

        @(negedge clk); rv_a = 8'h20;
        @(negedge clk); rv_a = 8'h00;
        @(negedge clk);
        rdslot_a = 3'd5;
        #1;
        chk("rel_idle_dv", dv_a, 8'h03);
        chk("rel_idle_len", rdlen_a, 0);
        chk("rel_idle_err", err_a, 8'h00);

        for (int i = 2; i < 8; i++) begin
            send(64'(i), 8'hFF, 1'b1);
        end
        repeat (3) @(negedge clk);
        chk("full_dv", dv_a, 8'hFF);
        chk("full_nwr", qa_addr.size(), 6);
        chk("full_addr7", qa_addr[5], 12'hE00);
        chk("full_data7", qa_data[5], {64'h0, 64'h7});
        clear_q();

        @(negedge clk);
        tdata = 64'h55; tkeep = 8'hFF; tlast = 1'b1; tvalid = 1'b1;
        repeat (4) @(negedge clk);
        chk("full_tready", rdy_a, 0);
        chk("full_nowr", qa_addr.size(), 0);
        rv_a = 8'h08;
        @(negedge clk); rv_a = 8'h00;
        chk("rel3_dv", dv_a, 8'hF7);
        chk("rel3_tready", rdy_a, 1);
        @(posedge clk); #1;
        tvalid = 1'b0;
        chk("rel3_wren", we_a, 1);
        chk("rel3_addr", wa_a, 12'h600);
        chk("rel3_data", wd_a, {64'h0, 64'h55});
        repeat (2) @(negedge clk);
        chk("rel3_dv_full", dv_a, 8'hFF);

        rv_a = 8'hFF;
        @(negedge clk); rv_a = 8'h00;
        @(negedge clk);
        chk("relall_dv", dv_a, 8'h00);
        send(64'h0101010101010101, 8'hFF, 1'b0);
        send(64'h0202020202020202, 8'hFF, 1'b0);
        send(64'h0303030303030303, 8'hFF, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_tready", rdy_a, 0);
        chk("mid_rst_wren", we_a, 0);
        chk("mid_rst_wrdata", wd_a, 0);
        chk("mid_rst_wraddr", wa_a, 0);
        chk("mid_rst_dv", dv_a, 0);
        chk("mid_rst_ovf", ovf_a, 0);
        rst_n = 1'b1;
        clear_q();
        send(64'h7777777777777777, 8'hFF, 1'b0);
        send(64'h8888888888888888, 8'hFF, 1'b1);
        repeat (3) @(negedge clk);
        chk("post_rst_nwr", qa_addr.size(), 1);
        chk("post_rst_addr", qa_addr[0], 12'h000);
        chk("post_rst_data", qa_data[0], {64'h8888888888888888, 64'h7777777777777777});
        chk("post_rst_dv", dv_a, 8'h01);
        clear_q();

        sel = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(64'(i) * 64'h0101010101010101, 8'hFF, i == 10);
        end
        repeat (3) @(negedge clk);
        chk("ovf_nwr", qb_addr.size(), 4);
        chk("ovf_addr3", qb_addr[3], 5'h03);
        chk("ovf_data3", qb_data[3], {64'h0808080808080808, 64'h0707070707070707});
        chk("ovf_err", err_b, 8'h01);
        chk("ovf_dv", dv_b, 8'h01);
        chk("ovf_rdlen", rdlen_b, 3'd4);
        chk("ovf_cnt", ovf_b, 16'd1);
        chk("ovf_a_quiet", qa_addr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
